// File: rtl/regex_instr_mem_responder_if.sv
// rtl/regex_instr_mem_responder_if.sv - regex_cpu instruction-fetch bus, one request/grant lane per port
interface regex_instr_mem_responder_if #(
    parameter int N_PORTS           = 2,
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11
);
    logic [N_PORTS-1:0]                   memory_valid;
    logic [N_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr;
    logic [N_PORTS-1:0]                   memory_ready;
    logic [N_PORTS*MEMORY_WIDTH-1:0]      memory_data;

    modport master (
        output memory_valid,
        output memory_addr,
        input  memory_ready,
        input  memory_data
    );

    modport slave (
        input  memory_valid,
        input  memory_addr,
        output memory_ready,
        output memory_data
    );
endinterface

// File: rtl/regex_instr_mem_responder.sv
// rtl/regex_instr_mem_responder.sv - round-robin instruction memory responder; REGEX_MEM_PERF_CNT_EN adds per-port fetch counters
module regex_instr_mem_responder #(
    parameter int N_PORTS           = 2,
    parameter int MEMORY_WIDTH      = 20,
    parameter int MEMORY_ADDR_WIDTH = 11
) (
    input  logic                         clk,
    input  logic                         rst,
    regex_instr_mem_responder_if.slave   mem_if,
    input  logic                         prog_we,
    input  logic [MEMORY_ADDR_WIDTH-1:0] prog_addr,
    input  logic [MEMORY_WIDTH-1:0]      prog_data
`ifdef REGEX_MEM_PERF_CNT_EN
    ,
    output logic [N_PORTS*32-1:0]        fetch_count
`endif
);
    localparam int DEPTH = 1 << MEMORY_ADDR_WIDTH;
    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                         state;
    logic [PTR_W-1:0]               ptr;
    logic [PTR_W-1:0]               grant_q;
    logic [MEMORY_ADDR_WIDTH-1:0]   addr_q;
    logic [MEMORY_WIDTH-1:0]        mem [DEPTH];

    logic [PTR_W:0]                 cand;
    logic [PTR_W-1:0]               gnt_idx;
    logic                           gnt_found;
    logic [MEMORY_ADDR_WIDTH-1:0]   gnt_addr;

    // Program port writes regardless of FSM state or reset; reads in GRANT see the old word.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // First requester at or after the round-robin pointer, wrapping at N_PORTS.
    always_comb begin
        cand      = '0;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            cand = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand >= (PTR_W+1)'(N_PORTS)) begin
                cand = cand - (PTR_W+1)'(N_PORTS);
            end
            if (!gnt_found && mem_if.memory_valid[cand[PTR_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        gnt_addr = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (gnt_idx == PTR_W'(p)) begin
                gnt_addr = mem_if.memory_addr[p*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            ptr                 <= '0;
            grant_q             <= '0;
            addr_q              <= '0;
            mem_if.memory_ready <= '0;
            mem_if.memory_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        for (int p = 0; p < N_PORTS; p++) begin
                            mem_if.memory_ready[p] <= (gnt_idx == PTR_W'(p));
                        end
                        grant_q <= gnt_idx;
                        addr_q  <= gnt_addr;
                        ptr     <= (gnt_idx == PTR_W'(N_PORTS-1)) ? '0 : gnt_idx + 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    for (int p = 0; p < N_PORTS; p++) begin
                        if (grant_q == PTR_W'(p)) begin
                            mem_if.memory_data[p*MEMORY_WIDTH +: MEMORY_WIDTH] <= mem[addr_q];
                        end
                    end
                    mem_if.memory_ready <= '0;
                    state               <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REGEX_MEM_PERF_CNT_EN
    logic [31:0] cnt [N_PORTS];

    // Counts completed deliveries (GRANT->IDLE) and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < N_PORTS; p++) begin
                cnt[p] <= '0;
            end
        end else if (state == GRANT) begin
            for (int p = 0; p < N_PORTS; p++) begin
                if (grant_q == PTR_W'(p) && cnt[p] != 32'hFFFF_FFFF) begin
                    cnt[p] <= cnt[p] + 32'd1;
                end
            end
        end
    end

    for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt
        assign fetch_count[p*32 +: 32] = cnt[p];
    end
`endif
endmodule

// File: tb/tb_regex_instr_mem_responder.sv
// tb/tb_regex_instr_mem_responder.sv - directed self-checking bench for regex_instr_mem_responder
module tb_regex_instr_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_we = 1'b0;
    logic [10:0] prog_addr = '0;
    logic [19:0] prog_data = '0;
    int          tests_run = 0;
    int          tests_failed = 0;

    regex_instr_mem_responder_if #(.N_PORTS(2), .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11)) bus();

`ifdef REGEX_MEM_PERF_CNT_EN
    logic [63:0] fetch_count;
`endif

    regex_instr_mem_responder #(.N_PORTS(2), .MEMORY_WIDTH(20), .MEMORY_ADDR_WIDTH(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_if    (bus),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
`ifdef REGEX_MEM_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    logic [19:0] data0, data1;
    assign data0 = bus.memory_data[19:0];
    assign data1 = bus.memory_data[39:20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [10:0] a, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        prog_write(11'd5, 20'h3A5C1);
        prog_write(11'd10, 20'h11111);
        prog_write(11'd20, 20'h22222);
        prog_write(11'd7, 20'hFFFFF);
        do_reset();
        tests_run++;
        if (bus.memory_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_ready got %b want 00", bus.memory_ready);
        end
        tests_run++;
        if (bus.memory_data !== 40'h0) begin
            tests_failed++;
            $display("FAIL reset_data got %h want 0", bus.memory_data);
        end
    endtask

    task automatic test_single_fetch();
        bus.memory_valid = 2'b01;
        bus.memory_addr  = {11'd0, 11'd5};
        #1;
        tests_run++;
        if (bus.memory_ready !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_ready_early got %b want 00", bus.memory_ready);
        end
        tick();
        tests_run++;
        if (bus.memory_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL single_ready got %b want 01", bus.memory_ready);
        end
        bus.memory_valid = 2'b00;
        tick();
        tests_run++;
        if (bus.memory_ready !== 2'b00 || data0 !== 20'h3A5C1 || data1 !== 20'h0) begin
            tests_failed++;
            $display("FAIL single_data got ready=%b d0=%h d1=%h want 00 3a5c1 00000",
                     bus.memory_ready, data0, data1);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.memory_valid = 2'b11;
        bus.memory_addr  = {11'd20, 11'd10};
        tick();
        tests_run++;
        if (bus.memory_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL simul_first_ready got %b want 01", bus.memory_ready);
        end
        bus.memory_valid = 2'b10;
        tick();
        tests_run++;
        if (bus.memory_ready !== 2'b00 || data0 !== 20'h11111 || data1 !== 20'h0) begin
            tests_failed++;
            $display("FAIL simul_first_data got ready=%b d0=%h d1=%h want 00 11111 00000",
                     bus.memory_ready, data0, data1);
        end
        tick();
        tests_run++;
        if (bus.memory_ready !== 2'b10) begin
            tests_failed++;
            $display("FAIL simul_second_ready got %b want 10", bus.memory_ready);
        end
        bus.memory_valid = 2'b00;
        tick();
        tests_run++;
        if (data0 !== 20'h11111 || data1 !== 20'h22222) begin
            tests_failed++;
            $display("FAIL simul_second_data got d0=%h d1=%h want 11111 22222", data0, data1);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_ready;
        do_reset();
        bus.memory_valid = 2'b11;
        bus.memory_addr  = {11'd20, 11'd10};
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k % 2 == 1) begin
                exp_ready = ((((k - 1) / 2) % 2) == 0) ? 2'b01 : 2'b10;
            end else begin
                exp_ready = 2'b00;
            end
            tests_run++;
            if (bus.memory_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rr_cycle%0d got %b want %b", k, bus.memory_ready, exp_ready);
            end
        end
        tests_run++;
        if (data0 !== 20'h11111 || data1 !== 20'h22222) begin
            tests_failed++;
            $display("FAIL rr_data got d0=%h d1=%h want 11111 22222", data0, data1);
        end
        bus.memory_valid = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_read_first();
        do_reset();
        bus.memory_valid = 2'b01;
        bus.memory_addr  = {11'd0, 11'd7};
        tick();
        bus.memory_valid = 2'b00;
        prog_we   = 1'b1;
        prog_addr = 11'd7;
        prog_data = 20'h00001;
        tick();
        prog_we = 1'b0;
        tests_run++;
        if (data0 !== 20'hFFFFF) begin
            tests_failed++;
            $display("FAIL read_first_old got %h want fffff", data0);
        end
        bus.memory_valid = 2'b01;
        tick();
        tests_run++;
        if (bus.memory_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL read_first_regrant got %b want 01", bus.memory_ready);
        end
        bus.memory_valid = 2'b00;
        tick();
        tests_run++;
        if (data0 !== 20'h00001) begin
            tests_failed++;
            $display("FAIL read_first_new got %h want 00001", data0);
        end
    endtask

    task automatic test_reset_in_grant();
        do_reset();
        bus.memory_valid = 2'b01;
        bus.memory_addr  = {11'd20, 11'd5};
        tick();
        bus.memory_valid = 2'b00;
        rst       = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 11'd30;
        prog_data = 20'h0ABCD;
        tick();
        rst     = 1'b0;
        prog_we = 1'b0;
        tests_run++;
        if (bus.memory_ready !== 2'b00 || bus.memory_data !== 40'h0) begin
            tests_failed++;
            $display("FAIL rst_grant got ready=%b data=%h want 00 0", bus.memory_ready, bus.memory_data);
        end
        bus.memory_valid = 2'b11;
        bus.memory_addr  = {11'd20, 11'd30};
        tick();
        tests_run++;
        if (bus.memory_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL rst_grant_next got %b want 01", bus.memory_ready);
        end
        bus.memory_valid = 2'b00;
        tick();
        tests_run++;
        if (data0 !== 20'h0ABCD || data1 !== 20'h0) begin
            tests_failed++;
            $display("FAIL rst_grant_write got d0=%h d1=%h want 0abcd 00000", data0, data1);
        end
    endtask

`ifdef REGEX_MEM_PERF_CNT_EN
    task automatic test_perf_count();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            bus.memory_valid = 2'b10;
            bus.memory_addr  = {11'd20, 11'd0};
            tick();
            bus.memory_valid = 2'b00;
            tick();
        end
        tests_run++;
        if (fetch_count[63:32] !== 32'd3 || fetch_count[31:0] !== 32'd0) begin
            tests_failed++;
            $display("FAIL perf_count got c1=%0d c0=%0d want 3 0", fetch_count[63:32], fetch_count[31:0]);
        end
        do_reset();
        tests_run++;
        if (fetch_count !== 64'h0) begin
            tests_failed++;
            $display("FAIL perf_clear got %h want 0", fetch_count);
        end
    endtask
`endif

    initial begin
        bus.memory_valid = 2'b00;
        bus.memory_addr  = '0;
        tick();
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_back_to_back();
        test_read_first();
        test_reset_in_grant();
`ifdef REGEX_MEM_PERF_CNT_EN
        test_perf_count();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/regex_instr_mem_responder.md
Name: regex_instr_mem_responder

Overview:
Memory-side responder for the regex_cpu instruction-fetch interface (memory_valid/memory_addr/memory_ready/memory_data). It holds the regex program in an on-chip single-read-port array and serves fetches from N_PORTS CPUs through a round-robin arbiter. It returns one instruction word per grant with a fixed registered timing that matches the CPU's fetch sequence. A separate write port loads the program before or between matches.

Parameters:
N_PORTS, 2, number of regex_cpu fetch ports served
MEMORY_WIDTH, 20, instruction word width in bits
MEMORY_ADDR_WIDTH, 11, address width; depth = 2**MEMORY_ADDR_WIDTH words

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
memory_valid  input  N_PORTS  per-port fetch request; CPU holds it high with a stable address until its memory_ready pulse
memory_addr  input  N_PORTS*MEMORY_ADDR_WIDTH  per-port fetch address; port i occupies slice [i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH]
memory_ready  output  N_PORTS  per-port one-cycle grant pulse
memory_data  output  N_PORTS*MEMORY_WIDTH  per-port registered instruction word; held between grants
prog_we  input  1  program write enable
prog_addr  input  MEMORY_ADDR_WIDTH  program write address
prog_data  input  MEMORY_WIDTH  program write data

Behaviour:
- Reset values: memory_ready = 0, every memory_data slice = 0, state = IDLE, round-robin pointer = 0. Memory contents are not cleared by reset.
- FSM states:
  - IDLE: if any memory_valid bit is high, grant the first requesting port at or after the pointer (wrap from N_PORTS-1 to 0). At the clock edge: memory_ready[g] <= 1, addr_q <= addr slice g, pointer <= g+1 mod N_PORTS, state -> GRANT. With no request, stay in IDLE.
  - GRANT: memory_ready[g] is high for exactly this one cycle. At the clock edge: memory_data slice g <= mem[addr_q], memory_ready <= 0, state -> IDLE.
- Timing: the request is seen in cycle T, ready is high in T+1, and the data is valid from T+2. The CPU samples the data in T+2, while ready is low.
- Throughput is at most one fetch every 2 cycles. A port can be regranted no earlier than T+2 and only if its valid is still high. No new grant is issued in the cycle when a port's ready is high.
- At most one memory_ready bit is high in any cycle.
- memory_data of non-granted ports never changes.
- Fairness: with all ports requesting continuously, grants rotate 0,1,...,N_PORTS-1,0,...
- Program write: mem[prog_addr] <= prog_data at the edge, independent of the FSM.
  - Write and read of the same address at the same edge: the read returns the old word (read-first).
  - A write has no effect on memory_ready timing.
- If memory_valid[g] drops while in GRANT (protocol violation), the data is still delivered and the FSM returns to IDLE normally.
- rst asserted in GRANT: at that edge memory_ready -> 0, memory_data is zeroed (reset has priority), and the FSM goes to IDLE. Any prog_we at that edge still writes.
- Addresses cover the full depth; there is no out-of-range case.

Optional Feature:
Macro REGEX_MEM_PERF_CNT_EN.
- Defined: adds output fetch_count (N_PORTS*32 bits), one 32-bit counter per port.
  - The counter increments at each GRANT->IDLE transition of its port.
  - The counter saturates at 0xFFFFFFFF.
  - The counter is cleared by rst.
- Undefined: the port and the counters are absent, and behaviour is otherwise identical.

Test Plan:
- Preload mem[5] = 0x3A5C1 via prog_we; reset; port 0 requests addr 5 -> memory_ready[0] is high exactly 1 cycle after valid, memory_data[0] = 0x3A5C1 on the following cycle, memory_ready[1] stays 0.
- Ports 0 and 1 request simultaneously (addr 10, 20) from reset -> port 0 is granted first, port 1 two cycles later, and each receives its own word; the other port's data slice is unchanged.
- Both ports request continuously for 8 grants -> grant order 0,1,0,1,... with no cycle where both ready bits are high and no back-to-back ready cycles.
- prog_we writes 0x00001 to addr 7 at the same edge that GRANT reads addr 7, which held 0xFFFFF -> memory_data = 0xFFFFF; the next fetch of addr 7 returns 0x00001.
- Assert rst during GRANT -> memory_ready is 0 next cycle, memory_data is 0, and the next request is granted normally to port 0.
- With REGEX_MEM_PERF_CNT_EN: 3 fetches on port 1 -> fetch_count slice 1 = 3 and slice 0 = 0; rst clears both.
